// File: rtl/seg2hex_scan_if.sv
// Bundles the segment/digit-select capture inputs and the decoded frame
// outputs of seg2hex_scan; master drives the scan, slave is the decoder.
interface seg2hex_scan_if #(
  parameter int NDIG = 6
) ();
  logic [7:0]        seg_d;
  logic [NDIG-1:0]   com;
  logic              sample_en;
  logic              out_ack;
  logic [4*NDIG-1:0] hex_out;
  logic [NDIG-1:0]   dp_out;
  logic [NDIG-1:0]   sep_out;
  logic [NDIG-1:0]   err_out;
  logic              out_valid;
  logic              overflow;
  logic              bad_com;

  modport master (
    output seg_d, com, sample_en, out_ack,
    input  hex_out, dp_out, sep_out, err_out, out_valid, overflow, bad_com
  );

  modport slave (
    input  seg_d, com, sample_en, out_ack,
    output hex_out, dp_out, sep_out, err_out, out_valid, overflow, bad_com
  );
endinterface

// File: rtl/seg2hex_scan.sv
// Captures a multiplexed seven-segment display, debounces each digit and
// presents whole decoded frames with a valid/ack hold.
//
// state   | meaning
// COLLECT | no frame presented; waiting for every digit to commit
// HOLD    | frame presented on outputs until the consumer acknowledges
module seg2hex_scan #(
  parameter int NDIG   = 6,
  parameter int STABLE = 2
) (
  input logic           clk,
  input logic           rst,
  seg2hex_scan_if.slave bus
);

  typedef enum logic {COLLECT, HOLD} state_t;

  typedef struct packed {
    logic [3:0] nib;
    logic       sep;
    logic       err;
  } dec_t;

  localparam logic [2:0] STABLE_C = 3'(STABLE);

  function automatic dec_t decode(input logic [6:0] pat);
    dec_t r;
    r = '0;
    case (pat)
      7'h3f: r.nib = 4'h0;
      7'h06: r.nib = 4'h1;
      7'h5b: r.nib = 4'h2;
      7'h4f: r.nib = 4'h3;
      7'h66: r.nib = 4'h4;
      7'h6d: r.nib = 4'h5;
      7'h7d: r.nib = 4'h6;
      7'h27: r.nib = 4'h7;
      7'h7f: r.nib = 4'h8;
      7'h6f: r.nib = 4'h9;
      7'h5f: r.nib = 4'ha;
      7'h7c: r.nib = 4'hb;
      7'h58: r.nib = 4'hc;
      7'h5e: r.nib = 4'hd;
      7'h7b: r.nib = 4'he;
      7'h71: r.nib = 4'hf;
      7'h49: r.sep = 1'b1;
      default: r.err = 1'b1;
    endcase
    return r;
  endfunction

  state_t            state_q, state_d;
  logic [7:0]        raw_q [NDIG];
  logic [7:0]        raw_d [NDIG];
  logic [2:0]        cnt_q [NDIG];
  logic [2:0]        cnt_d [NDIG];
  logic [NDIG-1:0]   seen_q, seen_d;
  logic [4*NDIG-1:0] wk_hex_q, wk_hex_d;
  logic [NDIG-1:0]   wk_dp_q, wk_dp_d;
  logic [NDIG-1:0]   wk_sep_q, wk_sep_d;
  logic [NDIG-1:0]   wk_err_q, wk_err_d;
  logic [4*NDIG-1:0] hex_q, hex_d;
  logic [NDIG-1:0]   dp_q, dp_d;
  logic [NDIG-1:0]   sep_q, sep_d;
  logic [NDIG-1:0]   err_q, err_d;
  logic              valid_q, valid_d;
  logic              ovf_q, ovf_d;
  logic              badcom_q, badcom_d;

  logic com_onehot;
  logic capture;
  logic frame_done;
  dec_t dec;

  assign com_onehot = (bus.com != '0) && ((bus.com & (bus.com - NDIG'(1))) == '0);
  assign capture    = bus.sample_en && com_onehot;
  assign frame_done = &seen_q;

  always_comb begin
    state_d  = state_q;
    raw_d    = raw_q;
    cnt_d    = cnt_q;
    seen_d   = seen_q;
    wk_hex_d = wk_hex_q;
    wk_dp_d  = wk_dp_q;
    wk_sep_d = wk_sep_q;
    wk_err_d = wk_err_q;
    hex_d    = hex_q;
    dp_d     = dp_q;
    sep_d    = sep_q;
    err_d    = err_q;
    valid_d  = valid_q;
    ovf_d    = ovf_q;
    badcom_d = badcom_q | (bus.sample_en && !com_onehot);
    dec      = decode(bus.seg_d[6:0]);

    // A completed frame clears its seen bits first so a commit on the same
    // edge already counts toward the next frame.
    if (frame_done) seen_d = '0;

    if (capture) begin
      for (int i = 0; i < NDIG; i++) begin
        if (bus.com[i]) begin
          if (bus.seg_d == raw_q[i]) begin
            cnt_d[i] = (cnt_q[i] >= STABLE_C) ? STABLE_C : cnt_q[i] + 3'd1;
          end else begin
            raw_d[i] = bus.seg_d;
            cnt_d[i] = 3'd1;
          end
          if (cnt_d[i] == STABLE_C) begin
            wk_hex_d[4*i +: 4] = dec.nib;
            wk_dp_d[i]         = bus.seg_d[7];
            wk_sep_d[i]        = dec.sep;
            wk_err_d[i]        = dec.err;
            seen_d[i]          = 1'b1;
          end
        end
      end
    end

    case (state_q)
      COLLECT: begin
        if (frame_done) begin
          hex_d   = wk_hex_q;
          dp_d    = wk_dp_q;
          sep_d   = wk_sep_q;
          err_d   = wk_err_q;
          valid_d = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (frame_done) begin
          if (bus.out_ack) begin
            hex_d = wk_hex_q;
            dp_d  = wk_dp_q;
            sep_d = wk_sep_q;
            err_d = wk_err_q;
          end else begin
            ovf_d = 1'b1;
          end
        end else if (bus.out_ack) begin
          valid_d = 1'b0;
          state_d = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= COLLECT;
      for (int i = 0; i < NDIG; i++) begin
        raw_q[i] <= '0;
        cnt_q[i] <= '0;
      end
      seen_q   <= '0;
      wk_hex_q <= '0;
      wk_dp_q  <= '0;
      wk_sep_q <= '0;
      wk_err_q <= '0;
      hex_q    <= '0;
      dp_q     <= '0;
      sep_q    <= '0;
      err_q    <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      badcom_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      raw_q    <= raw_d;
      cnt_q    <= cnt_d;
      seen_q   <= seen_d;
      wk_hex_q <= wk_hex_d;
      wk_dp_q  <= wk_dp_d;
      wk_sep_q <= wk_sep_d;
      wk_err_q <= wk_err_d;
      hex_q    <= hex_d;
      dp_q     <= dp_d;
      sep_q    <= sep_d;
      err_q    <= err_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      badcom_q <= badcom_d;
    end
  end

  assign bus.hex_out   = hex_q;
  assign bus.dp_out    = dp_q;
  assign bus.sep_out   = sep_q;
  assign bus.err_out   = err_q;
  assign bus.out_valid = valid_q;
  assign bus.overflow  = ovf_q;
  assign bus.bad_com   = badcom_q;

endmodule

// File: tb/tb_seg2hex_scan.sv
// Directed scoreboard bench for seg2hex_scan: stimulus pushes expected frames,
// a negedge monitor pops and compares every newly presented frame.
module tb_seg2hex_scan;
  localparam int NDIG = 6;

  logic clk = 1'b0;
  logic rst;

  seg2hex_scan_if #(.NDIG(NDIG)) bus ();

  seg2hex_scan #(.NDIG(NDIG), .STABLE(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [23:0] hex;
    logic [5:0]  dp;
    logic [5:0]  sep;
    logic [5:0]  err;
  } frame_t;

  frame_t exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Monitor: a frame is "presented" when out_valid rises or the held
  // snapshot changes while valid (concurrent-ack reload).
  logic   prev_valid = 1'b0;
  frame_t prev_f     = '0;
  always @(negedge clk) begin
    frame_t cur;
    frame_t e;
    cur = {bus.hex_out, bus.dp_out, bus.sep_out, bus.err_out};
    if (bus.out_valid === 1'b1 && (!prev_valid || cur != prev_f)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL frame_unexpected: got hex=%h dp=%b sep=%b err=%b, expected no frame",
                 cur.hex, cur.dp, cur.sep, cur.err);
      end else begin
        e = exp_q.pop_front();
        if (cur !== e) begin
          errors++;
          $display("FAIL frame: got hex=%h dp=%b sep=%b err=%b, expected hex=%h dp=%b sep=%b err=%b",
                   cur.hex, cur.dp, cur.sep, cur.err, e.hex, e.dp, e.sep, e.err);
        end
      end
    end
    prev_valid = (bus.out_valid === 1'b1);
    prev_f     = cur;
  end

  task automatic cap(input int d, input logic [7:0] s);
    @(negedge clk);
    bus.com       = '0;
    bus.com[d]    = 1'b1;
    bus.seg_d     = s;
    bus.sample_en = 1'b1;
    @(negedge clk);
    bus.sample_en = 1'b0;
    bus.com       = '0;
  endtask

  task automatic cap2(input int d, input logic [7:0] s);
    cap(d, s);
    cap(d, s);
  endtask

  task automatic bad_sample(input logic [5:0] c, input logic [7:0] s);
    @(negedge clk);
    bus.com       = c;
    bus.seg_d     = s;
    bus.sample_en = 1'b1;
    @(negedge clk);
    bus.sample_en = 1'b0;
    bus.com       = '0;
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_hex"}, bus.hex_out, 0);
    chk({tag, "_dp"}, bus.dp_out, 0);
    chk({tag, "_sep"}, bus.sep_out, 0);
    chk({tag, "_err"}, bus.err_out, 0);
    chk({tag, "_valid"}, bus.out_valid, 0);
    chk({tag, "_overflow"}, bus.overflow, 0);
    chk({tag, "_bad_com"}, bus.bad_com, 0);
  endtask

  logic [7:0] enc [6];

  initial begin
    enc[0] = 8'h06; enc[1] = 8'h5b; enc[2] = 8'h4f;
    enc[3] = 8'h66; enc[4] = 8'h6d; enc[5] = 8'h7d;
    rst = 1'b1;
    bus.seg_d = '0; bus.com = '0; bus.sample_en = 1'b0; bus.out_ack = 1'b0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;

    // Frame A: digits 1..6 with latency check on the final commit.
    exp_q.push_back({24'h654321, 6'b0, 6'b0, 6'b0});
    for (int i = 0; i < NDIG; i++) cap2(i, enc[i]);
    chk("latency_commit_edge", bus.out_valid, 0);
    @(negedge clk);
    chk("latency_next_edge", bus.out_valid, 1);
    @(negedge clk);
    bus.out_ack = 1'b1;
    @(negedge clk);
    bus.out_ack = 1'b0;
    chk("ack_clears_valid", bus.out_valid, 0);
    chk("bad_com_initially_clear", bus.bad_com, 0);

    // Ack while collecting is ignored.
    bus.out_ack = 1'b1;
    @(negedge clk);
    bus.out_ack = 1'b0;
    chk("ack_in_collect", bus.out_valid, 0);

    // Frame B: replace-then-stabilise, separator+dp, illegal pattern, bad com.
    exp_q.push_back({24'hE0F0B1, 6'b000100, 6'b000100, 6'b010000});
    cap(0, 8'h3f);
    cap(0, 8'h06);
    cap(0, 8'h06);
    cap2(1, 8'h7c);
    cap2(2, 8'hc9);
    cap2(3, 8'h71);
    cap2(4, 8'h00);
    cap(5, 8'h7b);
    bad_sample(6'b100001, 8'h7b);
    bad_sample(6'b000011, 8'h7b);
    @(negedge clk);
    chk("bad_com_no_count", bus.out_valid, 0);
    chk("bad_com_set", bus.bad_com, 1);
    cap(5, 8'h7b);
    repeat (2) @(negedge clk);
    chk("frame_b_valid", bus.out_valid, 1);

    // Frame completion with concurrent ack reloads, no overflow.
    exp_q.push_back({24'h999999, 6'b0, 6'b0, 6'b0});
    for (int i = 0; i < NDIG - 1; i++) cap2(i, 8'h6f);
    cap(5, 8'h6f);
    @(negedge clk);
    bus.com[5] = 1'b1; bus.seg_d = 8'h6f; bus.sample_en = 1'b1;
    @(negedge clk);
    bus.sample_en = 1'b0; bus.com = '0; bus.out_ack = 1'b1;
    @(negedge clk);
    bus.out_ack = 1'b0;
    chk("reload_valid", bus.out_valid, 1);
    chk("reload_no_overflow", bus.overflow, 0);

    // Frame completion in HOLD without ack: overflow, outputs held.
    for (int i = 0; i < NDIG; i++) cap2(i, 8'h7f);
    repeat (2) @(negedge clk);
    chk("overflow_set", bus.overflow, 1);
    chk("overflow_hex_held", bus.hex_out, 24'h999999);
    chk("overflow_valid_held", bus.out_valid, 1);
    chk("bad_com_sticky", bus.bad_com, 1);

    // Reset in HOLD.
    pulse_rst();
    chk_all_zero("rst_hold");

    // Reset mid-collection, then every digit must re-qualify.
    for (int i = 0; i < 3; i++) cap2(i, enc[i]);
    pulse_rst();
    chk("rst_mid_valid", bus.out_valid, 0);
    chk("rst_mid_hex", bus.hex_out, 0);
    for (int i = 3; i < NDIG; i++) cap2(i, enc[i]);
    repeat (2) @(negedge clk);
    chk("fresh_seen_cleared", bus.out_valid, 0);
    for (int i = 0; i < 3; i++) cap(i, enc[i]);
    repeat (2) @(negedge clk);
    chk("fresh_count_cleared", bus.out_valid, 0);
    exp_q.push_back({24'h654321, 6'b0, 6'b0, 6'b0});
    for (int i = 0; i < 3; i++) cap(i, enc[i]);
    repeat (2) @(negedge clk);
    chk("fresh_frame_valid", bus.out_valid, 1);
    chk("fresh_no_overflow", bus.overflow, 0);

    repeat (3) @(negedge clk);
    chk("scoreboard_drain", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg2hex_scan.md
SEG2HEX_SCAN -- requirements
Module: seg2hex_scan

Interface
REQ-001 Parameter NDIG, default 6, SHALL set the number of multiplexed digits captured.
REQ-002 Parameter STABLE, default 2, range 1..7, SHALL set the number of consecutive identical captures needed to commit a digit.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 seg_d  input  8  segment drive, active-high; bit7 = decimal point, bits6:0 = segments g..a.
REQ-006 com  input  NDIG  digit select, active-high, one-hot expected; bit i = digit i.
REQ-007 sample_en  input  1  capture strobe; seg_d/com SHALL be sampled only when high.
REQ-008 out_ack  input  1  consumer acknowledge of the current frame.
REQ-009 hex_out  output  4*NDIG  decoded nibbles; digit i at bits [4i+3:4i].
REQ-010 dp_out, sep_out, err_out  output  NDIG each  per-digit decimal point, separator and illegal-pattern flags.
REQ-011 out_valid  output  1  frame snapshot on hex_out/dp_out/sep_out/err_out is valid.
REQ-012 overflow, bad_com  output  1 each  sticky error flags.

Function
REQ-013 Decode of seg_d[7:0] with bit7 masked SHALL be: 3f->0, 06->1, 5b->2, 4f->3, 66->4, 6d->5, 7d->6, 27->7, 7f->8, 6f->9, 5f->A, 7c->B, 58->C, 5e->D, 7b->E, 71->F.
REQ-014 Masked pattern 49 SHALL decode to nibble 0 with sep=1, err=0; any pattern not in REQ-013 and not 49 SHALL decode to nibble 0 with err=1.
REQ-015 dp SHALL equal seg_d[7], independent of the decode.
REQ-016 A capture occurs on a sample_en cycle with exactly one com bit set; zero or multiple bits set SHALL discard the sample and set bad_com.
REQ-017 Per digit, a raw 8-bit pattern and a saturating match counter (0..STABLE) SHALL be kept; capture equal to stored raw -> counter+1 saturating; differing -> raw replaced, counter=1.
REQ-018 A capture whose resulting counter equals STABLE SHALL commit: digit's decoded nibble/dp/sep/err written to the working register and its seen bit set, on the capture edge.
REQ-019 FSM states COLLECT and HOLD; reset state COLLECT.
REQ-020 Frame complete = all NDIG seen bits set; on the edge after completion the working registers SHALL be copied to the outputs, out_valid SHALL rise, all seen bits SHALL clear, state -> HOLD.
REQ-021 HOLD: outputs and out_valid SHALL remain stable until out_ack=1; out_ack in HOLD -> out_valid=0 next edge, state -> COLLECT.
REQ-022 Collection SHALL continue during HOLD; a frame completing in HOLD without out_ack in the same cycle SHALL set overflow, clear seen bits, and leave outputs unchanged.
REQ-023 Frame completion and out_ack in the same HOLD cycle SHALL reload outputs with the new frame, keep out_valid=1, stay in HOLD, not set overflow.
REQ-024 out_ack in COLLECT SHALL have no effect.
REQ-025 Latency: commit of final digit at edge E -> out_valid=1 after edge E+1.

Reset
REQ-026 rst=1 at a rising edge SHALL set hex_out, dp_out, sep_out, err_out, out_valid, overflow, bad_com, all raw patterns, counters, seen bits and working registers to 0, and state to COLLECT, including mid-frame and in HOLD.
REQ-027 Sticky flags overflow and bad_com SHALL clear only by reset.

Verification
REQ-028 STABLE=2, NDIG=6; each digit i driven twice with encodings of 1,2,3,4,5,6 -> out_valid=1 one edge after last commit, hex_out=24'h654321, err_out=0.
REQ-029 Digit 0 sampled 3f then 06 then 06 -> committed nibble 1 (first capture replaced, counter 1 then 2); seg_d=C9 on digit 2 twice -> sep_out[2]=1, dp_out[2]=1.
REQ-030 seg_d=00 committed on digit 4 -> err_out[4]=1, hex nibble 0; com=6'b000011 with sample_en -> bad_com=1, no counter changes.
REQ-031 out_valid held, no out_ack, second full frame committed -> overflow=1, outputs unchanged; out_ack concurrent with completion -> outputs reload, out_valid stays 1, overflow unchanged.
REQ-032 rst asserted in HOLD and mid-collection -> all outputs 0 next edge; subsequent frame needs fresh STABLE captures for every digit.
